// File: rtl/common_pkg.sv
// Shared constants and types for the clock measurement blocks.
`timescale 1ns/10ps
package common_pkg;

    localparam int METER_WIDTH       = 28;
    localparam int METER_SYNC_STAGES = 2;
    // Divide ratio of the CPU clock divider; benches use it for expected periods.
    localparam int CLOCK_DIVISOR     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level, with a history flop
// producing single-cycle rise/fall pulses in the clk_in domain.
`timescale 1ns/10ps
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              hist_reg;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= sig;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                sync_reg[gi] <= 1'b0;
            end else begin
                sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hist_reg <= 1'b0;
        end else begin
            hist_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~hist_reg;
    assign fall = ~sync_reg[STAGES-1] & hist_reg;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of an asynchronous clock-like input in clk_in cycles.
// Optional high-phase measurement is enabled by defining CLOCK_METER_DUTY_EN.
`timescale 1ns/10ps
module clock_period_meter
    import common_pkg::*;
#(
    parameter int WIDTH       = METER_WIDTH,
    parameter int SYNC_STAGES = METER_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_meas,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
`ifdef CLOCK_METER_DUTY_EN
    output logic [WIDTH-1:0] high_time,
`endif
    output logic             stalled
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    meter_state_t     state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] period_reg;
    logic             period_valid_reg;
    logic             load_period;
    logic             rise;
`ifdef CLOCK_METER_DUTY_EN
    logic             fall;
    logic [WIDTH-1:0] pend_reg;
    logic [WIDTH-1:0] high_time_reg;
`endif

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig    (clk_meas),
        .rise   (rise),
`ifdef CLOCK_METER_DUTY_EN
        .fall   (fall)
`else
        .fall   ()
`endif
    );

    // A rise always restarts the count; saturation only matters without one.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        load_period = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (rise) begin
                    count_next = CNT_ONE;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    load_period = 1'b1;
                    count_next  = CNT_ONE;
                end else if (count_reg == CNT_MAX) begin
                    state_next = STALLED;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            STALLED: begin
                if (rise) begin
                    count_next = CNT_ONE;
                    state_next = MEASURE;
                end
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            period_valid_reg <= load_period;
            if (load_period) begin
                period_reg <= count_reg;
            end
        end
    end

`ifdef CLOCK_METER_DUTY_EN
    // High time is staged so it publishes together with the matching period.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pend_reg      <= '0;
            high_time_reg <= '0;
        end else begin
            if (state_reg == MEASURE && fall) begin
                pend_reg <= count_reg;
            end
            if (load_period) begin
                high_time_reg <= pend_reg;
            end
        end
    end

    assign high_time = high_time_reg;
`endif

    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign stalled      = (state_reg == STALLED);

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period of a slow, asynchronous clock-like input in cycles of the system clock `clk_in`. It is the receive-side counterpart to the clock divider: it turns a divided or external clock back into a cycle count. It is used to self-check the divided CPU clock, and to measure external step clocks feeding the core. It reports one period measurement per detected rising edge, with a valid pulse and a stall flag.

## Interface
- `WIDTH`, default 28: width of the period counter and outputs. Matches the divider range.
- `SYNC_STAGES`, default 2: flip-flop stages in the input synchronizer. Minimum 2.
- `clk_in`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high. Clock is `clk_in`.
- `clk_meas`, input, 1: signal to be measured. Asynchronous to `clk_in`.
- `period`, output, `WIDTH`: last completed period, in `clk_in` cycles. Holds its value between updates.
- `period_valid`, output, 1: one-cycle pulse when `period` (and `high_time`, if enabled) updates.
- `stalled`, output, 1: high while no rising edge has arrived within 2^`WIDTH`-1 cycles.
- `high_time`, output, `WIDTH`: high-phase length in cycles. Present only with `CLOCK_METER_DUTY_EN`.

## Operation
- **Synchronizer.** `clk_meas` passes through `SYNC_STAGES` flops, then one history flop.
  - `rise` = last stage AND NOT history.
  - `fall` = NOT last stage AND history.
  - Both are combinational, single-cycle pulses.
- **FSM states:** IDLE, MEASURE, STALLED. Reset state is IDLE.
- **IDLE.** Counter is held at 0.
  - On `rise`: counter <= 1, go to MEASURE, no `period_valid`.
- **MEASURE.** Counter increments by 1 each cycle.
  - On `rise`: `period` <= counter, `period_valid` <= 1, counter <= 1, stay in MEASURE.
  - If the counter reaches 2^`WIDTH`-1 with no `rise`: go to STALLED.
- **STALLED.** `stalled` = 1, the counter holds at its maximum, `period` is unchanged.
  - On `rise`: counter <= 1, go to MEASURE, `stalled` <= 0, no `period_valid`. The stalled interval is discarded.
- **Arithmetic.** Unsigned and saturating. The counter never wraps.
- **Period definition.** With `rise` detected in cycles t and t+P, `period` = P.
  - Minimum reportable period is 2, since the synchronizer limits the input to toggling no faster than every cycle.
- **Simultaneous events.** `rise` in the same cycle the counter hits its maximum: `rise` wins, a valid measurement of 2^`WIDTH`-1 is reported, and the FSM stays in MEASURE.
- **Reset mid-operation.** Reset clears everything immediately, including synchronizer flops and the history flop. The first `rise` after reset only arms the meter (IDLE to MEASURE).

## Timing
- **Reset values:** `period` = 0, `period_valid` = 0, `stalled` = 0, `high_time` = 0, counter = 0, FSM = IDLE, synchronizer and history flops = 0.
- **Input-to-detection latency:** a `clk_meas` rising edge is seen as `rise` `SYNC_STAGES`+1 `clk_in` edges later (±1 cycle of metastability uncertainty).
- **Output latency:** `period_valid` and `period` are registered. They appear the cycle after `rise`, and `period_valid` is high for exactly one cycle.
- **First valid output:** the earliest `period_valid` follows the second detected rising edge after reset or after leaving STALLED.
- **`stalled` timing:** rises the cycle after the counter reaches its maximum, and falls the cycle after the next `rise`.

## Configuration
- **`CLOCK_METER_DUTY_EN` defined:**
  - On `fall` in MEASURE, latch counter into a pending high-time register.
  - On the next `period_valid`, `high_time` <= pending value, so `high_time` and `period` always update together.
  - A `fall` seen in IDLE or STALLED is ignored.
- **Not defined:** the `high_time` port, the pending register and the fall logic are absent. No other behaviour changes.

## Structure
- **Shared package `common_pkg`:**
  - `METER_WIDTH` = 28 (default for `WIDTH`).
  - `METER_SYNC_STAGES` = 2.
  - Enum `meter_state_t` {IDLE, MEASURE, STALLED}.
  - `CLOCK_DIVISOR`, reused by benches for expected values.
- **Sub-module `sync_edge_detect`:** synchronizer, history flop, and `rise`/`fall` outputs. It is reused by other async-input blocks.

## Test plan
- **Divider loopback.** Drive `clk_meas` from a divide-by-4 generator (2 high, 2 low).
  - After the second edge, `period_valid` pulses every 4 cycles with `period` = 4.
  - With the macro defined, `high_time` = 2.
- **Frequency change.** Run a divisor of 10, then switch to 16.
  - The first valid after the switch reports a transitional value.
  - All following valids report 16.
  - `stalled` stays 0 throughout.
- **Stall and recovery.** Use `WIDTH` = 8 and hold `clk_meas` low 300 cycles after a rise.
  - `stalled` = 1 from counter 255 onward, and `period` is unchanged.
  - The next rise clears `stalled` with no valid.
  - The following rise gives a correct period.
- **Reset mid-measure.** Assert `rst` partway through a divisor-6 stream.
  - All outputs read 0 on the same edge.
  - After release, the first rise gives no valid; the second gives `period` = 6.
- **Boundary.** Use `WIDTH` = 8 with a rise exactly at counter 255.
  - `period` = 255 with `period_valid` = 1.
  - `stalled` never asserts.
- **Asynchronous jitter.** Drive a `clk_meas` period of 7.3 `clk_in` cycles with random phase.
  - Each reported `period` is 7 or 8.
  - Over 1000 samples the mean is within ±0.05 of 7.3.
